// File: rtl/bht_restore.sv
// Purpose: reload the 2-bit-counter BHT from a packed memory image read through a D$ load port.
// Latency: per 64-bit word >=1 REQ + 1 TAG + memory latency + up to 21 WRITE cycles; done_o 1 cycle after last write.
// Backpressure: REQ holds data_req and a stable index until data_gnt; WAIT stalls until data_rvalid.

package bht_restore_pkg;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;
endpackage

module bht_restore
  import bht_restore_pkg::*;
#(
  parameter int unsigned NR_ENTRIES   = 1024,
  parameter int unsigned ENT_PER_WORD = 21,
  localparam int unsigned AW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [63:0]   base_addr_i,
  output logic          busy_o,
  output logic          done_o,
  output dcache_req_i_t req_port_o,
  input  dcache_req_o_t req_port_i,
  output logic          bht_we_o,
  output logic [AW-1:0] bht_waddr_o,
  output logic          bht_wvalid_o,
  output logic [1:0]    bht_wctr_o
);

  localparam int unsigned NR_WORDS = (NR_ENTRIES + ENT_PER_WORD - 1) / ENT_PER_WORD;
  localparam int unsigned WCW      = (NR_WORDS > 1) ? $clog2(NR_WORDS) : 1;
  localparam int unsigned SW       = $clog2(ENT_PER_WORD);
  localparam int unsigned ADW      = DCACHE_INDEX_WIDTH + DCACHE_TAG_WIDTH;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NR_ENTRIES - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(ENT_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_TAG,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      base_q, base_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [AW-1:0]    ent_idx_q, ent_idx_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [63:0]      word_q, word_d;

  logic [ADW-1:0]   rd_addr;
  logic [5:0]       bit_pos;
  logic [2:0]       ent_bits;

  // Current word address and the 3-bit entry selected by the slot counter.
  always_comb begin
    rd_addr  = ADW'(base_q + {{(64-WCW-3){1'b0}}, word_cnt_q, 3'b000});
    bit_pos  = 6'(slot_q) * 6'd3;
    ent_bits = 3'(word_q >> bit_pos);
  end

  // Next-state and output decode; abort and reset suppress any side effect of the current cycle.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    word_cnt_d   = word_cnt_q;
    ent_idx_d    = ent_idx_q;
    slot_d       = slot_q;
    word_d       = word_q;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    req_port_o   = '0;
    bht_we_o     = 1'b0;
    bht_waddr_o  = '0;
    bht_wvalid_o = 1'b0;
    bht_wctr_o   = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d     = base_addr_i & ~64'h7;
          word_cnt_d = '0;
          ent_idx_d  = '0;
          slot_d     = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        busy_o                   = 1'b1;
        req_port_o.data_req      = 1'b1;
        req_port_o.data_be       = 8'hFF;
        req_port_o.data_size     = 2'b11;
        req_port_o.address_index = rd_addr[DCACHE_INDEX_WIDTH-1:0];
        if (req_port_i.data_gnt) begin
          state_d = S_TAG;
        end
      end
      S_TAG: begin
        busy_o                   = 1'b1;
        req_port_o.tag_valid     = 1'b1;
        req_port_o.address_index = rd_addr[DCACHE_INDEX_WIDTH-1:0];
        req_port_o.address_tag   = rd_addr[ADW-1:DCACHE_INDEX_WIDTH];
        req_port_o.data_be       = 8'hFF;
        req_port_o.data_size     = 2'b11;
        req_port_o.kill_req      = abort_i;
        // A zero-latency hit can return data in the tag cycle itself.
        if (req_port_i.data_rvalid) begin
          word_d  = req_port_i.data_rdata;
          slot_d  = '0;
          state_d = S_WRITE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        busy_o              = 1'b1;
        req_port_o.kill_req = abort_i;
        if (req_port_i.data_rvalid) begin
          word_d  = req_port_i.data_rdata;
          slot_d  = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        busy_o       = 1'b1;
        bht_we_o     = 1'b1;
        bht_waddr_o  = ent_idx_q;
        bht_wvalid_o = ent_bits[2];
        bht_wctr_o   = ent_bits[1:0];
        ent_idx_d    = ent_idx_q + 1'b1;
        slot_d       = slot_q + 1'b1;
        if (ent_idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else if (slot_q == LAST_SLOT) begin
          slot_d     = '0;
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = S_REQ;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a start in the same cycle.
    if (abort_i) begin
      state_d             = S_IDLE;
      done_o              = 1'b0;
      bht_we_o            = 1'b0;
      req_port_o.data_req = 1'b0;
    end
    if (rst_i) begin
      bht_we_o = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      word_cnt_q <= '0;
      ent_idx_q  <= '0;
      slot_q     <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      word_cnt_q <= word_cnt_d;
      ent_idx_q  <= ent_idx_d;
      slot_q     <= slot_d;
      word_q     <= word_d;
    end
  end

endmodule

// File: tb/tb_bht_restore.sv
// Purpose: self-checking bench for bht_restore with a D$ responder model and a spec-level reference.
// Latency: responder grant delay and data latency are configurable per run or randomized per request.
// Backpressure: grant is withheld for gnt_delay cycles of data_req; rvalid arrives rt_lat cycles after TAG.

module tb_bht_restore;
  import bht_restore_pkg::*;

  localparam int NR  = 1024;
  localparam int EPW = 21;
  localparam int NW  = (NR + EPW - 1) / EPW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [63:0]   base_addr;
  logic          busy;
  logic          done;
  dcache_req_i_t req_o;
  dcache_req_o_t req_i;
  logic          we;
  logic [9:0]    waddr;
  logic          wvalid;
  logic [1:0]    wctr;

  bht_restore #(.NR_ENTRIES(NR), .ENT_PER_WORD(EPW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .abort_i      (abort),
    .base_addr_i  (base_addr),
    .busy_o       (busy),
    .done_o       (done),
    .req_port_o   (req_o),
    .req_port_i   (req_i),
    .bht_we_o     (we),
    .bht_waddr_o  (waddr),
    .bht_wvalid_o (wvalid),
    .bht_wctr_o   (wctr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] idx;
    logic       v;
    logic [1:0] c;
  } wr_t;

  typedef struct {
    logic [63:0] word;
    int          slot;
    logic        v;
    logic [1:0]  c;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Memory image and responder knobs.
  logic [63:0] mem [0:63];
  logic [63:0] cur_base = '0;
  int          gnt_delay = 0;
  int          rt_lat = 0;
  bit          rand_lat = 1'b0;
  int          req_cycles = 0;
  int          pend = 0;
  logic [63:0] pend_data = '0;
  bit          last_gnt = 1'b0;

  // Monitor state.
  logic [63:0] rd_q [$];
  wr_t         wr_q [$];
  int          done_cnt = 0;
  int          dwe_cnt = 0;
  int          idx_unstable = 0;
  int          tag_no_gnt = 0;
  int          req_run = 0;
  int          max_req_run = 0;
  bit          prev_req = 1'b0;
  logic [DCACHE_INDEX_WIDTH-1:0] prev_index = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // D$ responder and output monitor, both on the falling edge.
  always @(negedge clk) begin
    logic [63:0] a;
    logic [63:0] off;
    logic [63:0] d;
    if (rst) begin
      req_i      = '0;
      req_cycles = 0;
      pend       = 0;
      last_gnt   = 1'b0;
      prev_req   = 1'b0;
      req_run    = 0;
    end else begin
      if (req_o.tag_valid && !last_gnt) tag_no_gnt++;
      if (req_o.data_req) begin
        if (prev_req && req_o.address_index != prev_index) idx_unstable++;
        req_run++;
        if (req_run > max_req_run) max_req_run = req_run;
      end else begin
        req_run = 0;
      end
      prev_req   = req_o.data_req;
      prev_index = req_o.address_index;

      req_i.data_gnt    = 1'b0;
      req_i.data_rvalid = 1'b0;
      req_i.data_rdata  = {$urandom, $urandom};
      if (req_o.data_req) begin
        if (req_cycles >= gnt_delay) begin
          req_i.data_gnt = 1'b1;
          req_cycles = 0;
          if (rand_lat) gnt_delay = $urandom_range(0, 3);
        end else begin
          req_cycles++;
        end
      end else begin
        req_cycles = 0;
      end
      last_gnt = req_i.data_gnt;

      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          req_i.data_rvalid = 1'b1;
          req_i.data_rdata  = pend_data;
        end
      end
      if (req_o.tag_valid) begin
        a   = {8'h00, req_o.address_tag, req_o.address_index};
        rd_q.push_back(a);
        off = a - cur_base;
        d   = (off[2:0] == 3'b000 && off < 64'd512) ? mem[off[8:3]] : 64'h0;
        if (rand_lat) rt_lat = $urandom_range(0, 3);
        if (rt_lat == 0) begin
          req_i.data_rvalid = 1'b1;
          req_i.data_rdata  = d;
        end else begin
          pend      = rt_lat;
          pend_data = d;
        end
      end

      if (we) wr_q.push_back('{waddr, wvalid, wctr});
      if (done) done_cnt++;
      if (req_o.data_we) dwe_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_q.delete();
    wr_q.delete();
    done_cnt     = 0;
    idx_unstable = 0;
    tag_no_gnt   = 0;
    max_req_run  = 0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 64; k++) mem[k] = {$urandom, $urandom};
  endtask

  task automatic start_run(input logic [63:0] b);
    cur_base  = b & ~64'h7;
    base_addr = b;
    start     = 1'b1;
    cyc(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cyc(1);
      n++;
    end
    check({name, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    cyc(3);
  endtask

  // Reference: entry i lives in word i/21, slot i%21, three bits per slot.
  function automatic logic [2:0] model_ent(input int i);
    logic [63:0] w;
    w = mem[i / EPW];
    return 3'((w >> (3 * (i % EPW))) & 64'h7);
  endfunction

  task automatic check_run(input string name);
    logic [63:0] exp_a;
    int          n_last = 0;
    check({name, "_reads"}, 64'(rd_q.size()), 64'(NW));
    for (int k = 0; k < NW && k < rd_q.size(); k++) begin
      exp_a = (cur_base + 64'(8 * k)) & 64'h00FF_FFFF_FFFF_FFFF;
      check($sformatf("%s_addr%0d", name, k), rd_q[k], exp_a);
    end
    check({name, "_writes"}, 64'(wr_q.size()), 64'(NR));
    for (int i = 0; i < NR && i < wr_q.size(); i++) begin
      check($sformatf("%s_wr%0d", name, i), {wr_q[i].idx, wr_q[i].v, wr_q[i].c}, {10'(i), model_ent(i)});
      if (int'(wr_q[i].idx) >= (NW - 1) * EPW) n_last++;
    end
    check({name, "_last_word_writes"}, 64'(n_last), 64'(NR - (NW - 1) * EPW));
    check({name, "_done_once"}, 64'(done_cnt), 64'd1);
    check({name, "_no_store"}, 64'(dwe_cnt), 64'd0);
    check({name, "_tag_after_gnt"}, 64'(tag_no_gnt), 64'd0);
  endtask

  initial begin
    vec_t tbl [10];
    bit   found;
    int   n_before;

    tbl[0] = '{64'h2F,                  0,  1'b1, 2'd3};
    tbl[1] = '{64'h2F,                  1,  1'b1, 2'd1};
    tbl[2] = '{64'h2F,                  2,  1'b0, 2'd0};
    tbl[3] = '{64'h2F,                  20, 1'b0, 2'd0};
    tbl[4] = '{64'h8000_0000_0000_0000, 20, 1'b0, 2'd0};
    tbl[5] = '{64'h7000_0000_0000_0000, 20, 1'b1, 2'd3};
    tbl[6] = '{64'h4000_0000_0000_0000, 20, 1'b1, 2'd0};
    tbl[7] = '{64'h0000_0000_0000_0002, 0,  1'b0, 2'd2};
    tbl[8] = '{64'h0000_0000_8000_0000, 10, 1'b0, 2'd2};
    tbl[9] = '{64'h0000_0004_0000_0000, 11, 1'b0, 2'd2};

    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    for (int k = 0; k < 64; k++) mem[k] = '0;
    cyc(3);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_we", 64'(we), 64'd0);
    check("reset_req", 64'(req_o != '0), 64'd0);
    rst = 1'b0;
    cyc(2);

    // Full restore: fixed latencies, 0x1FFF.. patterns plus table words in the first words.
    gnt_delay = 2;
    rt_lat    = 1;
    rand_lat  = 1'b0;
    for (int k = 0; k < 64; k++) mem[k] = 64'h1FFF_FFFF_FFFF_FFFF ^ (64'(k) << 7);
    for (int r = 0; r < 10; r++) mem[r] = tbl[r].word;
    clear_mon();
    start_run(64'h8000_1000);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_done("full", 5000);
    check_run("full");
    for (int r = 0; r < 10; r++) begin
      int j;
      j = r * EPW + tbl[r].slot;
      check($sformatf("vec%0d", r),
            (j < wr_q.size()) ? 64'({wr_q[j].v, wr_q[j].c}) : 64'hDEAD,
            64'({tbl[r].v, tbl[r].c}));
    end
    check("idle_after_done", 64'(busy), 64'd0);

    // Abort in WAIT of word 5, unaligned base, late rvalid after abort.
    fill_random();
    gnt_delay = 1;
    rt_lat    = 4;
    clear_mon();
    start_run(64'h8000_2004);
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      cyc(1);
      if (rd_q.size() == 6 && busy && !req_o.data_req && !req_o.tag_valid && !we) found = 1'b1;
    end
    check("abort_reached_wait", 64'(found), 64'd1);
    abort = 1'b1;
    start = 1'b1;
    #1;
    check("abort_kill_req", 64'(req_o.kill_req), 64'd1);
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_req", 64'(req_o != '0), 64'd0);
    cyc(10);
    check("abort_writes", 64'(wr_q.size()), 64'(5 * EPW));
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_reads", 64'(rd_q.size()), 64'd6);
    check("base_low_bits_dropped", (rd_q.size() > 0) ? rd_q[0] : 64'hDEAD, 64'h8000_2000);

    // Restart after abort with a slow grant and start pulses while busy.
    fill_random();
    gnt_delay = 10;
    rt_lat    = 0;
    clear_mon();
    start_run(64'h8000_2000);
    fork
      wait_done("slowgnt", 8000);
      begin
        for (int p = 0; p < 4; p++) begin
          cyc($urandom_range(5, 200));
          if (busy && done_cnt == 0) begin
            base_addr = 64'h8000_0000 + 64'($urandom_range(1, 4095) << 3);
            start     = 1'b1;
            cyc(1);
            start     = 1'b0;
          end
        end
      end
    join
    check_run("slowgnt");
    check("slowgnt_req_held", 64'(max_req_run >= 11), 64'd1);
    check("slowgnt_index_stable", 64'(idx_unstable), 64'd0);

    // Randomized latencies, images and bases.
    for (int r = 0; r < 2; r++) begin
      fill_random();
      rand_lat  = 1'b1;
      gnt_delay = $urandom_range(0, 3);
      clear_mon();
      start_run(64'h8000_0000 + 64'($urandom_range(0, 4095) << 3) + 64'($urandom_range(0, 7)));
      wait_done($sformatf("rand%0d", r), 6000);
      check_run($sformatf("rand%0d", r));
    end
    rand_lat = 1'b0;

    // Reset in the middle of WRITE.
    gnt_delay = 0;
    rt_lat    = 1;
    clear_mon();
    start_run(64'h8000_1000);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      cyc(1);
      if (we) found = 1'b1;
    end
    check("rst_reached_write", 64'(found), 64'd1);
    rst = 1'b1;
    cyc(1);
    check("rst_mid_we", 64'(we), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_req", 64'(req_o != '0), 64'd0);
    n_before = wr_q.size();
    rst = 1'b0;
    cyc(5);
    check("rst_mid_no_more_writes", 64'(wr_q.size()), 64'(n_before));
    check("rst_mid_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
